affine_acc_seq: RTL



---
 rtl/affine_acc_seq.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/affine_acc_seq.sv
`default_nettype none
// ============================================================================
// Module   : affine_acc_seq
// Purpose  : Streaming affine accumulator. Accepts one signed operand per
//            cycle, optionally negates it (bit inversion or exact negation,
//            selected by NEG_EXACT), and sums N_IN such terms modulo
//            2^OUT_W into one frame result. The result is held in a
//            valid/ready output register decoupled from the accumulator, so
//            the next frame accumulates while the previous result waits.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   DATA_W    - operand width (two's complement)
//   N_IN      - terms per frame (>= 2)
//   OUT_W     - result width; sum wraps modulo 2^OUT_W
//   NEG_EXACT - 0: negated term = ~x (-x-1); 1: negated term = -x
// Ports:
//   clock_i      in   clock, rising edge
//   reset_i      in   asynchronous active-high reset
//   clear_i      in   synchronous frame abort (held result untouched)
//   in_valid_i   in   operand beat present
//   in_ready_o   out  block can accept a beat
//   in_data_i    in   operand
//   in_inv_i     in   1 = negate this term
//   out_valid_o  out  frame result held
//   out_ready_i  in   downstream accepts result
//   out_data_o   out  frame sum
//   term_cnt_o   out  beats accepted in the current frame
// ============================================================================
module affine_acc_seq #(
  parameter int DATA_W    = 8,
  parameter int N_IN      = 16,
  parameter int OUT_W     = 12,
  parameter bit NEG_EXACT = 1'b0
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic                    clear_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [DATA_W-1:0]       in_data_i,
  input  logic                    in_inv_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [OUT_W-1:0]        out_data_o,
  output logic [$clog2(N_IN)-1:0] term_cnt_o
);

  localparam int              CNT_W    = $clog2(N_IN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_IN - 1);

  // Output holding register: EMPTY has no result, FULL presents one.
  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

  out_state_e        state_q, state_d;
  logic [OUT_W-1:0]  acc_q, acc_d;
  logic [OUT_W-1:0]  out_data_q, out_data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [OUT_W-1:0]  ext_w;
  logic [OUT_W-1:0]  term_w;
  logic [OUT_W-1:0]  sum_w;
  logic              is_last_w;
  logic              accept_w;
  logic              load_w;

  // --------------------------------------------------------------------------
  // Term formation
  // --------------------------------------------------------------------------
  // Size cast of a signed operand sign-extends to the result width.
  assign ext_w = OUT_W'(signed'(in_data_i));

  generate
    if (NEG_EXACT) begin : g_neg_exact
      // Two's-complement negation: invert and add one.
      assign term_w = in_inv_i ? (~ext_w + OUT_W'(1)) : ext_w;
    end else begin : g_neg_invert
      // Cheap one's-complement negation: ~x == -x-1.
      assign term_w = in_inv_i ? ~ext_w : ext_w;
    end
  endgenerate

  // Single OUT_W-bit adder shared by the accumulator and the result load;
  // overflow simply wraps.
  assign sum_w = acc_q + term_w;

  // --------------------------------------------------------------------------
  // Handshake decode
  // --------------------------------------------------------------------------
  assign is_last_w = (cnt_q == LAST_CNT);

  // Only the final beat of a frame ever stalls, and only when a result is
  // still held and downstream is not taking it this cycle. That is the one
  // combinational out_ready -> in_ready path.
  assign in_ready_o = ~(is_last_w && (state_q == FULL) && ~out_ready_i);

  assign accept_w = in_valid_i && in_ready_o;

  // A frame completes only on an accepted final beat that is not aborted.
  assign load_w = accept_w && is_last_w && ~clear_i;

  // --------------------------------------------------------------------------
  // Accumulator and beat counter
  // --------------------------------------------------------------------------
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      // Abort wins over accumulation; the concurrent beat is dropped.
      acc_d = '0;
      cnt_d = '0;
    end else if (accept_w) begin
      if (is_last_w) begin
        // Final beat: the sum leaves via the output register, so the
        // accumulator restarts for the next frame in the same cycle.
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = sum_w;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Output register state machine
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    case (state_q)
      EMPTY: begin
        if (load_w) begin
          state_d    = FULL;
          out_data_d = sum_w;
        end
      end
      FULL: begin
        if (load_w) begin
          // Load can only occur here when out_ready is high (otherwise the
          // final beat stalls), so the old result is consumed and replaced.
          out_data_d = sum_w;
        end else if (out_ready_i) begin
          state_d = EMPTY;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  // out_data is left untouched on unload; it only changes on a new load, so
  // it is trivially stable while stalled.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= EMPTY;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
    end
  end

  assign out_valid_o = (state_q == FULL);
  assign out_data_o  = out_data_q;
  assign term_cnt_o  = cnt_q;

endmodule
`default_nettype wire
